// File: rtl/io_mmio_ctrl.sv
// Memory-mapped IO controller: switch latches, test input, LEDs, queued 7-seg FIFO, blink timer, status.
// Optional IO_SEG_HOLD_LAST_EN: seg_out keeps the last popped word while the FIFO is empty.
module io_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FC00,
  parameter int unsigned N_IN       = 2,
  parameter int unsigned IN_W       = 8,
  parameter int unsigned TEST_W     = 3,
  parameter int unsigned SEG_W      = 24,
  parameter int unsigned LED_W      = 16,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned DISP_TICKS = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_read,
  input  logic              io_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       rdata,
  input  logic [IN_W-1:0]   sw_in,
  input  logic [N_IN-1:0]   enter,
  input  logic [TEST_W-1:0] test_in,
  output logic [SEG_W-1:0]  seg_out,
  output logic [LED_W-1:0]  led_out,
  output logic              blink_out,
  output logic              fifo_full
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMR_W = (DISP_TICKS > 1) ? $clog2(DISP_TICKS) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(DISP_TICKS - 1);

  localparam logic [31:0] OFF_TEST   = 32'h40;
  localparam logic [31:0] OFF_STATUS = 32'h44;
  localparam logic [31:0] OFF_SEG    = 32'h60;
  localparam logic [31:0] OFF_LED    = 32'h64;
  localparam logic [31:0] OFF_BLINK  = 32'h68;
  localparam logic [31:0] OFF_FLUSH  = 32'h6C;

  logic [IN_W-1:0]  r_in [N_IN];
  logic [LED_W-1:0] r_led;
  logic [SEG_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [TMR_W-1:0] r_timer;
  logic [31:0]      r_blink_cnt;
  logic             r_blink;

  logic [31:0] w_off;
  logic        w_wr_seg;
  logic        w_wr_led;
  logic        w_wr_blink;
  logic        w_flush;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic [31:0] w_status;
  logic [31:0] w_blink_nxt;

  assign w_off      = addr - BASE_ADDR;
  assign w_wr_seg   = io_write && (w_off == OFF_SEG);
  assign w_wr_led   = io_write && (w_off == OFF_LED);
  assign w_wr_blink = io_write && (w_off == OFF_BLINK);
  assign w_flush    = io_write && (w_off == OFF_FLUSH);

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  // A pop frees a slot on the same edge, so a push into a full FIFO is accepted then.
  assign w_pop    = !w_empty && (r_timer == '0);
  assign w_push   = w_wr_seg && (!w_full || w_pop);
  assign w_status = {16'b0, 8'(r_count), 5'b0, r_ovf, w_full, w_empty};

  // Read mux: IO registers on a matched read, otherwise data memory.
  always_comb begin
    rdata = mem_rdata;
    if (io_read) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (w_off == 32'(4 * i)) rdata = 32'(r_in[i]);
      end
      if (w_off == OFF_TEST)   rdata = 32'(test_in);
      if (w_off == OFF_STATUS) rdata = w_status;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_IN); i++) r_in[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (enter[i]) r_in[i] <= sw_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           r_led <= '0;
    else if (w_wr_led) r_led <= wdata[LED_W-1:0];
  end

  always_comb begin
    w_blink_nxt = r_blink_cnt;
    if (w_wr_blink)              w_blink_nxt = wdata;
    else if (r_blink_cnt != '0)  w_blink_nxt = r_blink_cnt - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_nxt;
      r_blink     <= (w_blink_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) r_fifo[r_wr_ptr] <= wdata[SEG_W-1:0];
  end

  // FIFO pointers, occupancy, sticky overflow and per-entry display timer.
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_timer  <= TMR_RELOAD;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr_seg && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_empty || w_pop) r_timer <= TMR_RELOAD;
      else                  r_timer <= r_timer - TMR_W'(1);
    end
  end

`ifdef IO_SEG_HOLD_LAST_EN
  logic [SEG_W-1:0] r_last;

  always_ff @(posedge clk) begin
    if (rst || w_flush) r_last <= '0;
    else if (w_pop)     r_last <= r_fifo[r_rd_ptr];
  end

  assign seg_out = w_empty ? r_last : r_fifo[r_rd_ptr];
`else
  assign seg_out = w_empty ? '0 : r_fifo[r_rd_ptr];
`endif

  assign led_out   = r_led;
  assign blink_out = r_blink;
  assign fifo_full = w_full;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Scoreboard bench for io_mmio_ctrl (FIFO_DEPTH=4, DISP_TICKS=4).
module tb_io_mmio_ctrl;

  localparam logic [31:0] BASE = 32'hFFFF_FC00;
  localparam int S_RD   = 0;
  localparam int S_SEG  = 1;
  localparam int S_LED  = 2;
  localparam int S_BLK  = 3;
  localparam int S_FULL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] rdata;
  logic [7:0]  sw_in;
  logic [1:0]  enter;
  logic [2:0]  test_in;
  logic [23:0] seg_out;
  logic [15:0] led_out;
  logic        blink_out;
  logic        fifo_full;

  io_mmio_ctrl #(.FIFO_DEPTH(4), .DISP_TICKS(4)) dut (
    .clk(clk), .rst(rst), .io_read(io_read), .io_write(io_write),
    .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata), .rdata(rdata),
    .sw_in(sw_in), .enter(enter), .test_in(test_in), .seg_out(seg_out),
    .led_out(led_out), .blink_out(blink_out), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned mcyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

`ifdef IO_SEG_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  function automatic logic [31:0] pick(int s);
    case (s)
      S_RD:    return rdata;
      S_SEG:   return 32'(seg_out);
      S_LED:   return 32'(led_out);
      S_BLK:   return 32'(blink_out);
      default: return 32'(fifo_full);
    endcase
  endfunction

  // Monitor: each negedge, compare every expectation scheduled for this cycle.
  initial begin
    logic [31:0] got;
    forever begin
      @(negedge clk);
      mcyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == mcyc) begin
          got = pick(sb[i].sig);
          n_cmp++;
          if (got !== sb[i].val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, got, sb[i].val, mcyc);
          end
          sb.delete(i);
        end
      end
    end
  end

  // Schedule an expectation d cycles after the current one.
  task automatic chk(input int sig, input logic [31:0] v, input int d, input string nm);
    exp_t e;
    e.cyc  = mcyc + 1 + int'(d);
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] v);
    io_write = 1'b1;
    addr     = BASE + off;
    wdata    = v;
    tick();
    io_write = 1'b0;
    addr     = '0;
    wdata    = '0;
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] v, input string nm);
    io_read = 1'b1;
    addr    = BASE + off;
    chk(S_RD, v, 0, nm);
    tick();
    io_read = 1'b0;
    addr    = '0;
  endtask

  initial begin
    rst = 1'b1; io_read = 1'b0; io_write = 1'b0; addr = '0; wdata = '0;
    mem_rdata = 32'hDEAD_BEEF; sw_in = '0; enter = '0; test_in = '0;
    tick(2);
    rst = 1'b0;

    // Reset state
    chk(S_SEG, 0, 0, "rst_seg"); chk(S_LED, 0, 0, "rst_led");
    chk(S_BLK, 0, 0, "rst_blink"); chk(S_FULL, 0, 0, "rst_full");
    rd(32'h44, 32'h1, "rst_status");

    // Switch latches, test input, read passthrough
    sw_in = 8'hA5; enter = 2'b10; tick();
    enter = 2'b00; sw_in = 8'h3C;
    rd(32'h04, 32'h0000_00A5, "in1_latched");
    rd(32'h00, 32'h0, "in0_untouched");
    enter = 2'b01; sw_in = 8'h11; tick(); sw_in = 8'h22; tick(); enter = 2'b00;
    rd(32'h00, 32'h22, "in0_held_enter");
    test_in = 3'b101;
    rd(32'h40, 32'h5, "test_in");
    rd(32'h50, 32'hDEAD_BEEF, "unmapped_read");
    addr = BASE + 32'h04;
    chk(S_RD, 32'hDEAD_BEEF, 0, "no_strobe_passthru");
    tick(); addr = '0;

    // LED register, unmapped write ignored
    wr(32'h64, 32'h1234_ABCD);
    chk(S_LED, 32'hABCD, 0, "led_write");
    wr(32'h70, 32'h5555_5555);
    chk(S_LED, 32'hABCD, 0, "led_unmapped_wr");

    // Two entries, each shown four cycles
    wr(32'h60, 32'h111);
    chk(S_SEG, 32'h111, 0, "disp_a_first"); chk(S_SEG, 32'h111, 3, "disp_a_last");
    chk(S_SEG, 32'h222, 4, "disp_b_first"); chk(S_SEG, 32'h222, 7, "disp_b_last");
    chk(S_SEG, HOLD ? 32'h222 : 32'h0, 8, "disp_empty");
    wr(32'h60, 32'h222);
    tick(10);

    // Fill, push on pop edge, then overflow while full
    wr(32'h60, 32'hB01); wr(32'h60, 32'hB02); wr(32'h60, 32'hB03);
    wr(32'h60, 32'hB04); wr(32'h60, 32'hB05);
    chk(S_SEG, 32'hB02, 0, "pop_push_seg"); chk(S_FULL, 1, 0, "pop_push_full");
    rd(32'h44, 32'h0000_0402, "pop_push_status");
    wr(32'h60, 32'hBAD);
    chk(S_FULL, 1, 0, "ovf_full");
    chk(S_SEG, 32'hB02, 1, "ovf_b2"); chk(S_SEG, 32'hB03, 2, "ovf_b3_first");
    chk(S_SEG, 32'hB03, 5, "ovf_b3_last"); chk(S_SEG, 32'hB04, 6, "ovf_b4");
    chk(S_FULL, 0, 2, "drain_not_full");
    chk(S_SEG, 32'hB05, 10, "ovf_b5_first"); chk(S_SEG, 32'hB05, 13, "ovf_b5_last");
    chk(S_SEG, HOLD ? 32'hB05 : 32'h0, 14, "ovf_dropped_never_shown");
    rd(32'h44, 32'h0000_0406, "ovf_status");
    tick(16);

    // Sticky overflow, then FLUSH
    rd(32'h44, 32'h0000_0005, "ovf_sticky");
    wr(32'h60, 32'hC01);
    chk(S_SEG, 32'hC01, 0, "pre_flush_seg");
    wr(32'h60, 32'hC02);
    wr(32'h6C, 32'hFFFF_FFFF);
    chk(S_SEG, 0, 0, "flush_seg"); chk(S_FULL, 0, 0, "flush_full");
    rd(32'h44, 32'h0000_0001, "flush_status");
    wr(32'h60, 32'hD01);
    chk(S_SEG, 32'hD01, 0, "post_flush_first"); chk(S_SEG, 32'hD01, 3, "post_flush_last");
    chk(S_SEG, HOLD ? 32'hD01 : 32'h0, 4, "post_flush_empty");
    tick(6);

    // Blink timer
    wr(32'h68, 32'd3);
    chk(S_BLK, 1, 0, "blink3_c0"); chk(S_BLK, 1, 2, "blink3_c2"); chk(S_BLK, 0, 3, "blink3_off");
    tick(5);
    wr(32'h68, 32'd3);
    chk(S_BLK, 1, 0, "blink_pre_reload");
    wr(32'h68, 32'd5);
    chk(S_BLK, 1, 0, "reload_c0"); chk(S_BLK, 1, 4, "reload_c4"); chk(S_BLK, 0, 5, "reload_off");
    tick(7);
    wr(32'h68, 32'd5);
    wr(32'h68, 32'd0);
    chk(S_BLK, 0, 0, "blink_stop");
    tick(2);

    // Reset mid-operation overrides a same-cycle write
    wr(32'h68, 32'd100);
    wr(32'h64, 32'h00F0);
    wr(32'h60, 32'hE01); wr(32'h60, 32'hE02); wr(32'h60, 32'hE03);
    chk(S_SEG, 32'hE01, 0, "pre_rst_seg"); chk(S_BLK, 1, 0, "pre_rst_blink");
    chk(S_LED, 32'h00F0, 0, "pre_rst_led");
    rst = 1'b1; io_write = 1'b1; addr = BASE + 32'h60; wdata = 32'hE04;
    tick();
    rst = 1'b0; io_write = 1'b0; addr = '0; wdata = '0;
    chk(S_SEG, 0, 0, "mid_rst_seg"); chk(S_BLK, 0, 0, "mid_rst_blink");
    chk(S_LED, 0, 0, "mid_rst_led"); chk(S_FULL, 0, 0, "mid_rst_full");
    rd(32'h44, 32'h0000_0001, "mid_rst_status");
    rd(32'h04, 32'h0, "mid_rst_in1");
    tick(3);

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
